display_arbiter: RTL and testbench
==================================

// Module: display_arbiter
// PURPOSE
//  Shares one multiplexed 7-segment display (Data2Segments) between Requesters data sources.
//  Round-robin grant; each grant held for a minimum dwell so a reading is human-legible.
//  Sits between producer blocks and the Data2Segments Data input; one instance per display.
// PARAMETERS
//  Size           4          width of each source word and of DisplayData (matches Data2Segments Size)
//  Requesters     4          number of sources, 2..16
//  ClockPeriod_ns 20         Clock period
//  DwellTime_ns   500_000_000 minimum grant hold; DwellCycles = DwellTime_ns/ClockPeriod_ns, elaboration error if <2
// PORTS
//  Clock        in  1                  system clock, all state on rising edge
//  Reset_n      in  1                  asynchronous, active-low reset
//  Request      in  Requesters         level request per source, held while source wants display
//  Data         in  [Requesters][Size] packed source words, Data[i] belongs to Request[i]
//  Grant        out Requesters         one-hot current owner, all-zero when idle
//  Source       out clog2(Requesters)  index of current owner, 0 when idle
//  DisplayData  out Size               registered copy of Data[Source], feeds Data2Segments
//  DisplayValid out 1                  1 while a grant is active
// BEHAVIOUR
//  Reset (async, Reset_n=0): Grant=0, Source=0, DisplayData=0, DisplayValid=0, state IDLE,
//   dwell counter=0, round-robin pointer=0; effective immediately, also mid-dwell.
//  States: IDLE, DWELL.
//  IDLE: if |Request, pick first requester at/after pointer (wrap-around), enter DWELL;
//   Grant/Source/DisplayValid update on that same edge (1-cycle request->grant latency).
//  DWELL: counter 0..DwellCycles-1, DisplayData <= Data[Source] every cycle (1-cycle latency, live updates).
//  Dwell expiry (counter==DwellCycles-1):
//   - other requester pending -> grant first pending after Source (current owner lowest priority),
//     counter=0, stay DWELL; pointer=new Source+1 mod Requesters.
//   - only current owner requesting -> keep grant, counter=0 (extension).
//   - none requesting -> IDLE, Grant=0, DisplayValid=0.
//  Owner drops Request before expiry: dwell aborted; next edge arbitrates as at expiry
//   (switch to another pending source or go IDLE). No dead cycle on switch.
//  New requests mid-dwell never pre-empt; they wait for expiry or owner drop.
//  Counter width clog2(DwellCycles); never exceeds DwellCycles-1.
//  Grant is one-hot or zero at all times; Source==index of Grant bit.
// CONFIGURATION
//  DISPLAY_ARBITER_BLANK_EN defined: while IDLE, DisplayData forced to all-ones
//   (renders blank/minus pattern downstream), reset value unchanged (0).
//  Not defined: while IDLE, DisplayData holds last shown word.
// STRUCTURE
//  Package General: enum DisplayArbState {IDLE, DWELL}; function RoundRobinPick(Request, Start)
//   returning index+found flag; reuse General::clog2.
//  One combinational sub-module round_robin_picker (Request, Start, Exclude -> Index, Found),
//   used for IDLE pick and expiry/abort pick.
//  Instantiate Data2Segments outside this block; no clock-enable prescaler inside.
// TESTING (Requesters=4, Size=4, ClockPeriod_ns=20, DwellTime_ns=200 -> DwellCycles=10)
//  1 Reset_n low mid-DWELL with Grant=0100 -> Grant=0, DisplayValid=0, DisplayData=0 with no clock edge.
//  2 IDLE, Request=0010, Data[1]=4'h7 -> next edge Grant=0010, Source=1; DisplayData=7 one edge later.
//  3 Request=1111 held -> grants 0001,0010,0100,1000,0001, each exactly 10 cycles, no gap.
//  4 Owner 0 drops Request at counter 3, Request=0100 -> Grant=0100 on next edge, counter=0.
//  5 Only Request=1000 held 35 cycles -> Grant=1000 continuous; then drop -> IDLE next edge.
//  6 With DISPLAY_ARBITER_BLANK_EN, go IDLE after showing 4'h5 -> DisplayData=4'hF; without -> stays 4'h5.

Source files
------------

// File: rtl/display_arbiter_pkg.sv
// Shared types and helpers for display_arbiter: FSM state enum, log2 helper,
// and the round-robin search used by round_robin_picker.
package display_arbiter_pkg;

  typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} DisplayArbState;

  typedef struct packed {
    logic       found;
    logic [3:0] index;
  } rr_pick_t;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // First set bit of Request at or after Start, wrapping within n (n <= 16, Start < n).
  function automatic rr_pick_t RoundRobinPick(input logic [15:0] Request,
                                              input logic [3:0]  Start,
                                              input int          n);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < n) begin
        idx = int'(Start) + k;
        if (idx >= n) idx = idx - n;
        if (!r.found && Request[idx[3:0]]) begin
          r.found = 1'b1;
          r.index = idx[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/display_arbiter_picker.sv
// Combinational round-robin picker: first requester at/after Start, skipping
// any source flagged in Exclude.
module round_robin_picker
  import display_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = clog2(N)
) (
  input  logic [N-1:0]  Request,
  input  logic [SW-1:0] Start,
  input  logic [N-1:0]  Exclude,
  output logic [SW-1:0] Index,
  output logic          Found
);

  logic [15:0] avail;
  rr_pick_t    pick;

  always_comb begin
    avail        = '0;
    avail[N-1:0] = Request & ~Exclude;
    pick         = RoundRobinPick(avail, 4'(Start), N);
  end

  assign Found = pick.found;
  assign Index = SW'(pick.index);

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner selection for one shared 7-segment display with a minimum dwell per grant.
// Optional DISPLAY_ARBITER_BLANK_EN: drive DisplayData to all-ones while IDLE.
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int  Size           = 4,
  parameter int  Requesters     = 4,
  parameter int  ClockPeriod_ns = 20,
  parameter int  DwellTime_ns   = 500_000_000,
  localparam int SW             = clog2(Requesters)
) (
  input  logic                                Clock,
  input  logic                                Reset_n,
  input  logic [Requesters-1:0]               Request,
  input  logic [Requesters-1:0][Size-1:0]     Data,
  output logic [Requesters-1:0]               Grant,
  output logic [SW-1:0]                       Source,
  output logic [Size-1:0]                     DisplayData,
  output logic                                DisplayValid
);

  localparam int DwellCycles = DwellTime_ns / ClockPeriod_ns;
  localparam int CW          = clog2(DwellCycles);
  localparam logic [CW-1:0] LastCnt = CW'(DwellCycles - 1);
  localparam logic [SW-1:0] LastSrc = SW'(Requesters - 1);

  if (DwellCycles < 2) begin : g_dwell_check
    $error("display_arbiter: DwellCycles must be at least 2");
  end
  if (Requesters < 2 || Requesters > 16) begin : g_req_check
    $error("display_arbiter: Requesters must be in 2..16");
  end

  DisplayArbState        state;
  logic [CW-1:0]         cnt;
  logic [SW-1:0]         ptr;
  logic [SW-1:0]         src_next, pick_start, pick_idx, pick_ptr;
  logic [Requesters-1:0] pick_excl, pick_onehot;
  logic                  pick_found, owner_req, rearb;

  // IDLE searches from the pointer; in DWELL the owner is searched last and excluded,
  // so a hit means some other source is waiting.
  always_comb begin
    src_next    = (Source == LastSrc) ? '0 : Source + SW'(1);
    pick_start  = (state == IDLE) ? ptr : src_next;
    pick_excl   = (state == IDLE) ? '0 : Grant;
    pick_onehot = Requesters'(1) << pick_idx;
    pick_ptr    = (pick_idx == LastSrc) ? '0 : pick_idx + SW'(1);
    owner_req   = Request[Source];
    rearb       = (cnt == LastCnt) || !owner_req;
  end

  round_robin_picker #(.N(Requesters), .SW(SW)) u_picker (
    .Request (Request),
    .Start   (pick_start),
    .Exclude (pick_excl),
    .Index   (pick_idx),
    .Found   (pick_found)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      Grant        <= '0;
      Source       <= '0;
      DisplayData  <= '0;
      DisplayValid <= 1'b0;
      cnt          <= '0;
      ptr          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state        <= DWELL;
            cnt          <= '0;
            Grant        <= pick_onehot;
            Source       <= pick_idx;
            DisplayValid <= 1'b1;
            ptr          <= pick_ptr;
          end
        end
        DWELL: begin
          if (rearb) begin
            cnt <= '0;
            if (pick_found) begin
              Grant  <= pick_onehot;
              Source <= pick_idx;
              ptr    <= pick_ptr;
            end else if (!owner_req) begin
              state        <= IDLE;
              Grant        <= '0;
              Source       <= '0;
              DisplayValid <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (state == DWELL) DisplayData <= Data[Source];
`ifdef DISPLAY_ARBITER_BLANK_EN
      else DisplayData <= '1;
`endif
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with a cycle-level behavioural model and literal checks.
module tb_display_arbiter;
  localparam int N  = 4;
  localparam int SZ = 4;
  localparam int DW = 10;

  logic                  Clock = 1'b0;
  logic                  Reset_n = 1'b0;
  logic [N-1:0]          Request = '0;
  logic [N-1:0][SZ-1:0]  Data = '0;
  logic [N-1:0]          Grant;
  logic [1:0]            Source;
  logic [SZ-1:0]         DisplayData;
  logic                  DisplayValid;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 Clock = ~Clock;

  display_arbiter #(.Size(SZ), .Requesters(N), .ClockPeriod_ns(20), .DwellTime_ns(200)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Request(Request), .Data(Data),
    .Grant(Grant), .Source(Source), .DisplayData(DisplayData), .DisplayValid(DisplayValid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner (-1 = none), cycles held, round-robin pointer, displayed word
  typedef struct packed {
    int          owner;
    int          held;
    int          ptr;
    logic [SZ-1:0] dd;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(input mstate_t s, input logic [N-1:0] req,
                                         input logic [N-1:0][SZ-1:0] d);
    mstate_t r = s;
    int      nxt = -1;
    if (s.owner < 0) begin
      for (int k = 0; k < N; k++)
        if (nxt < 0 && req[(s.ptr + k) % N]) nxt = (s.ptr + k) % N;
      if (nxt >= 0) begin
        r.owner = nxt; r.held = 0; r.ptr = (nxt + 1) % N;
      end
    end else if (s.held == DW - 1 || !req[s.owner]) begin
      for (int k = 1; k < N; k++)
        if (nxt < 0 && req[(s.owner + k) % N]) nxt = (s.owner + k) % N;
      r.held = 0;
      if (nxt >= 0) begin
        r.owner = nxt; r.ptr = (nxt + 1) % N;
      end else if (!req[s.owner]) begin
        r.owner = -1;
      end
    end else begin
      r.held = s.held + 1;
    end
    if (s.owner >= 0) r.dd = d[s.owner];
`ifdef DISPLAY_ARBITER_BLANK_EN
    else r.dd = '1;
`endif
    return r;
  endfunction

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) m <= '{owner: -1, held: 0, ptr: 0, dd: '0};
    else          m <= model_step(m, Request, Data);
  end

  always @(negedge Clock) begin
    if (Reset_n) begin
      check("model_grant", 32'(Grant), (m.owner < 0) ? 32'd0 : (32'd1 << m.owner));
      check("model_source", 32'(Source), (m.owner < 0) ? 32'd0 : 32'(m.owner));
      check("model_valid", 32'(DisplayValid), (m.owner < 0) ? 32'd0 : 32'd1);
      check("model_data", 32'(DisplayData), 32'(m.dd));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic do_reset();
    Request = '0;
    Reset_n = 1'b0;
    #3;
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  logic [N-1:0] pat_req [8] = '{4'b0011, 4'b0101, 4'b0000, 4'b1010, 4'b0110, 4'b1111, 4'b0001, 4'b0000};
  int           pat_len [8] = '{25, 7, 3, 14, 4, 31, 5, 2};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    #5;
    check("reset_grant", 32'(Grant), 32'd0);
    check("reset_source", 32'(Source), 32'd0);
    check("reset_valid", 32'(DisplayValid), 32'd0);
    check("reset_data", 32'(DisplayData), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Async reset in the middle of a dwell
    Request = 4'b0100;
    Data[2] = 4'h9;
    step(1);
    check("t1_grant_before", 32'(Grant), 32'h4);
    step(3);
    #4 Reset_n = 1'b0;
    #1;
    check("t1_grant", 32'(Grant), 32'd0);
    check("t1_valid", 32'(DisplayValid), 32'd0);
    check("t1_data", 32'(DisplayData), 32'd0);
    do_reset();

    // Single request from IDLE: one-cycle grant, data one edge later
    Request = 4'b0010;
    Data[1] = 4'h7;
    step(1);
    check("t2_grant", 32'(Grant), 32'h2);
    check("t2_source", 32'(Source), 32'd1);
    step(1);
    check("t2_data", 32'(DisplayData), 32'h7);
    do_reset();

    // All requesting: 10 cycles each in rotation, no gap
    Request = 4'b1111;
    step(1);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < DW; c++) begin
        check("t3_rotation", 32'(Grant), 32'd1 << (g % 4));
        step(1);
      end
    end
    do_reset();

    // Owner drops at counter 3 while source 2 waits
    Request = 4'b0001;
    step(4);
    check("t4_grant_before", 32'(Grant), 32'h1);
    Request = 4'b0100;
    step(1);
    check("t4_grant_after", 32'(Grant), 32'h4);
    check("t4_source_after", 32'(Source), 32'd2);
    do_reset();

    // Sole requester extends repeatedly, then drops to IDLE
    Request = 4'b1000;
    step(1);
    for (int c = 0; c < 35; c++) begin
      check("t5_hold", 32'(Grant), 32'h8);
      step(1);
    end
    Request = 4'b0000;
    step(1);
    check("t5_idle_grant", 32'(Grant), 32'd0);
    check("t5_idle_valid", 32'(DisplayValid), 32'd0);
    do_reset();

    // IDLE display behaviour after showing 5
    Data[0] = 4'h5;
    Request = 4'b0001;
    step(2);
    check("t6_shown", 32'(DisplayData), 32'h5);
    Request = 4'b0000;
    step(2);
`ifdef DISPLAY_ARBITER_BLANK_EN
    check("t6_idle_data", 32'(DisplayData), 32'hF);
`else
    check("t6_idle_data", 32'(DisplayData), 32'h5);
`endif
    do_reset();

    // Mixed request patterns with changing data, checked by the model every cycle
    for (int p = 0; p < 8; p++) begin
      Request = pat_req[p];
      for (int c = 0; c < pat_len[p]; c++) begin
        Data = 16'($urandom);
        step(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
